// File: rtl/crop_pkg.sv
// Shared definitions for the dynamic ROI crop: FSM encoding, default widths
// and the frame-start / last-pixel / span comparison helpers.
// Coordinate helpers work on CROP_CW_MAX-bit values. Callers zero-extend, so
// start+len never wraps as long as P_CW < CROP_CW_MAX.
package crop_pkg;

  localparam int unsigned CROP_DEPTH_DEF = 10;
  localparam int unsigned CROP_CH_DEF    = 3;
  localparam int unsigned CROP_CW_DEF    = 11;
  localparam int unsigned CROP_CW_MAX    = 16;

  typedef logic [CROP_CW_MAX-1:0] crop_coord_t;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_DONE     = 2'd2
  } crop_state_e;

  // Start of frame: first valid pixel at the origin.
  function automatic logic crop_is_sof(input logic valid, input crop_coord_t x,
                                       input crop_coord_t y);
    return valid && (x == '0) && (y == '0);
  endfunction

  // Bottom-right pixel of a non-empty window.
  function automatic logic crop_is_last(input logic valid,
                                        input crop_coord_t x, input crop_coord_t y,
                                        input crop_coord_t xs, input crop_coord_t xw,
                                        input crop_coord_t ys, input crop_coord_t yw);
    logic nz;
    nz = (xw != '0) && (yw != '0);
    return valid && nz &&
           (x == xs + xw - crop_coord_t'(1)) &&
           (y == ys + yw - crop_coord_t'(1));
  endfunction

  // Half-open span test: start <= v < start+len.
  function automatic logic crop_in_span(input crop_coord_t v, input crop_coord_t start,
                                        input crop_coord_t len);
    return (v >= start) && (v < start + len);
  endfunction

endpackage

// File: rtl/crop_cfg_shadow.sv
// Window configuration shadow: a pending set written by cfg_update and an
// active set that only takes the pending values at start of frame.
// Ports: clk/rst_n, cfg_* + cfg_update (pending write), sof_c (frame start),
//        act_* (registered active set), eff_*_c (config in force this cycle,
//        i.e. already reflecting a swap happening on the SOF pixel itself).
module crop_cfg_shadow #(
  parameter int unsigned P_CW = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [P_CW-1:0] cfg_x_start,
  input  logic [P_CW-1:0] cfg_x_win,
  input  logic [P_CW-1:0] cfg_y_start,
  input  logic [P_CW-1:0] cfg_y_win,
  input  logic            cfg_update,
  input  logic            sof_c,
  output logic [P_CW-1:0] act_xs,
  output logic [P_CW-1:0] act_xw,
  output logic [P_CW-1:0] act_ys,
  output logic [P_CW-1:0] act_yw,
  output logic [P_CW-1:0] eff_xs_c,
  output logic [P_CW-1:0] eff_xw_c,
  output logic [P_CW-1:0] eff_ys_c,
  output logic [P_CW-1:0] eff_yw_c
);

  logic [P_CW-1:0] pend_xs_q, pend_xw_q, pend_ys_q, pend_yw_q;
  logic [P_CW-1:0] pend_xs_d, pend_xw_d, pend_ys_d, pend_yw_d;
  logic [P_CW-1:0] act_xs_q, act_xw_q, act_ys_q, act_yw_q;
  logic [P_CW-1:0] act_xs_d, act_xw_d, act_ys_d, act_yw_d;
  logic            pend_vld_q, pend_vld_d;
  logic            swap_c;

  // Swap uses the pending set as it stood before this cycle; a cfg_update
  // coinciding with SOF refills pending for the following frame.
  always_comb begin
    pend_xs_d  = pend_xs_q;
    pend_xw_d  = pend_xw_q;
    pend_ys_d  = pend_ys_q;
    pend_yw_d  = pend_yw_q;
    act_xs_d   = act_xs_q;
    act_xw_d   = act_xw_q;
    act_ys_d   = act_ys_q;
    act_yw_d   = act_yw_q;
    pend_vld_d = pend_vld_q;
    swap_c     = sof_c && pend_vld_q;
    if (swap_c) begin
      act_xs_d   = pend_xs_q;
      act_xw_d   = pend_xw_q;
      act_ys_d   = pend_ys_q;
      act_yw_d   = pend_yw_q;
      pend_vld_d = 1'b0;
    end
    if (cfg_update) begin
      pend_xs_d  = cfg_x_start;
      pend_xw_d  = cfg_x_win;
      pend_ys_d  = cfg_y_start;
      pend_yw_d  = cfg_y_win;
      pend_vld_d = 1'b1;
    end
    eff_xs_c = swap_c ? pend_xs_q : act_xs_q;
    eff_xw_c = swap_c ? pend_xw_q : act_xw_q;
    eff_ys_c = swap_c ? pend_ys_q : act_ys_q;
    eff_yw_c = swap_c ? pend_yw_q : act_yw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_xs_q  <= '0;
      pend_xw_q  <= '0;
      pend_ys_q  <= '0;
      pend_yw_q  <= '0;
      act_xs_q   <= '0;
      act_xw_q   <= '0;
      act_ys_q   <= '0;
      act_yw_q   <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      pend_xs_q  <= pend_xs_d;
      pend_xw_q  <= pend_xw_d;
      pend_ys_q  <= pend_ys_d;
      pend_yw_q  <= pend_yw_d;
      act_xs_q   <= act_xs_d;
      act_xw_q   <= act_xw_d;
      act_ys_q   <= act_ys_d;
      act_yw_q   <= act_yw_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign act_xs = act_xs_q;
  assign act_xw = act_xw_q;
  assign act_ys = act_ys_q;
  assign act_yw = act_yw_q;

endmodule

// File: rtl/crop_roi_dyn.sv
// Runtime-configurable region-of-interest crop for the camera pixel stream.
// Two-cycle pipeline: stage 1 registers the pixel with window hit flags,
// stage 2 forms window-relative coordinates and gates the outputs.
// Ports: in_pclk/in_arstn, cfg_* + cfg_update (window config, applied at
//        next start of frame), in_x/in_y/in_valid/in_data (pixel in),
//        out_x/out_y/out_valid/out_hs/out_data (cropped pixel out),
//        out_frame_done (last window pixel), err_trunc (sticky truncation).
// Build option: CROP_DECIM2_EN adds 2:1 decimation in both axes.
module crop_roi_dyn
  import crop_pkg::*;
#(
  parameter int unsigned P_DEPTH = CROP_DEPTH_DEF,
  parameter int unsigned P_CH    = CROP_CH_DEF,
  parameter int unsigned P_CW    = CROP_CW_DEF
) (
  input  logic                    in_pclk,
  input  logic                    in_arstn,
  input  logic [P_CW-1:0]         cfg_x_start,
  input  logic [P_CW-1:0]         cfg_x_win,
  input  logic [P_CW-1:0]         cfg_y_start,
  input  logic [P_CW-1:0]         cfg_y_win,
  input  logic                    cfg_update,
  input  logic [P_CW-1:0]         in_x,
  input  logic [P_CW-1:0]         in_y,
  input  logic                    in_valid,
  input  logic [P_CH*P_DEPTH-1:0] in_data,
  output logic [P_CW-1:0]         out_x,
  output logic [P_CW-1:0]         out_y,
  output logic                    out_valid,
  output logic                    out_hs,
  output logic [P_CH*P_DEPTH-1:0] out_data,
  output logic                    out_frame_done,
  output logic                    err_trunc
);

  localparam int unsigned DW = P_CH * P_DEPTH;

  // Reset: asserts asynchronously, releases on the clock.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge in_pclk or negedge in_arstn) begin
    if (!in_arstn) rst_sync_q <= '0;
    else           rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  // Config shadow and window test.
  logic [P_CW-1:0] act_xs, act_xw, act_ys, act_yw;
  logic [P_CW-1:0] eff_xs_c, eff_xw_c, eff_ys_c, eff_yw_c;
  logic            sof_c, hit_x_c, hit_y_c, last_c, act_c, zero_act_c;

  assign sof_c = crop_is_sof(in_valid, crop_coord_t'(in_x), crop_coord_t'(in_y));

  crop_cfg_shadow #(.P_CW(P_CW)) u_shadow (
    .clk         (in_pclk),
    .rst_n       (rst_n),
    .cfg_x_start (cfg_x_start),
    .cfg_x_win   (cfg_x_win),
    .cfg_y_start (cfg_y_start),
    .cfg_y_win   (cfg_y_win),
    .cfg_update  (cfg_update),
    .sof_c       (sof_c),
    .act_xs      (act_xs),
    .act_xw      (act_xw),
    .act_ys      (act_ys),
    .act_yw      (act_yw),
    .eff_xs_c    (eff_xs_c),
    .eff_xw_c    (eff_xw_c),
    .eff_ys_c    (eff_ys_c),
    .eff_yw_c    (eff_yw_c)
  );

  assign hit_x_c = crop_in_span(crop_coord_t'(in_x), crop_coord_t'(eff_xs_c),
                                crop_coord_t'(eff_xw_c));
  assign hit_y_c = crop_in_span(crop_coord_t'(in_y), crop_coord_t'(eff_ys_c),
                                crop_coord_t'(eff_yw_c));
  assign last_c  = crop_is_last(in_valid, crop_coord_t'(in_x), crop_coord_t'(in_y),
                                crop_coord_t'(eff_xs_c), crop_coord_t'(eff_xw_c),
                                crop_coord_t'(eff_ys_c), crop_coord_t'(eff_yw_c));

  // Frame state, including the SOF pixel itself which opens the frame.
  crop_state_e state_q, state_d;
  logic        err_q, err_d;

  assign act_c      = sof_c || (state_q == ST_ACTIVE);
  assign zero_act_c = (act_xw == '0) || (act_yw == '0);

  // Next state and truncation flag; a zero-size frame never completes, so
  // its restart is not a truncation.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (cfg_update) err_d = 1'b0;
    unique case (state_q)
      ST_WAIT_SOF,
      ST_DONE:   if (sof_c) state_d = ST_ACTIVE;
      ST_ACTIVE: if (sof_c && !zero_act_c) err_d = 1'b1;
      default:   state_d = ST_WAIT_SOF;
    endcase
    if (act_c && last_c) state_d = ST_DONE;
  end

  always_ff @(posedge in_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_SOF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Stage 1: pixel plus window flags.
  logic            s1_valid_q, s1_valid_d;
  logic [P_CW-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [DW-1:0]   s1_data_q, s1_data_d;
  logic            s1_hit_x_q, s1_hit_x_d, s1_hit_y_q, s1_hit_y_d;
  logic            s1_act_q, s1_act_d, s1_last_q, s1_last_d;

  always_comb begin
    s1_valid_d = in_valid;
    s1_x_d     = in_x;
    s1_y_d     = in_y;
    s1_data_d  = in_data;
    s1_hit_x_d = hit_x_c;
    s1_hit_y_d = hit_y_c;
    s1_act_d   = act_c;
    s1_last_d  = act_c && last_c;
  end

  always_ff @(posedge in_pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_data_q  <= '0;
      s1_hit_x_q <= 1'b0;
      s1_hit_y_q <= 1'b0;
      s1_act_q   <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_data_q  <= s1_data_d;
      s1_hit_x_q <= s1_hit_x_d;
      s1_hit_y_q <= s1_hit_y_d;
      s1_act_q   <= s1_act_d;
      s1_last_q  <= s1_last_d;
    end
  end

  // Stage 2: relative coordinates and output gating. The active set here
  // always matches the one stage 1 used, since swaps only occur on SOF.
  logic [P_CW-1:0] rel_x_c, rel_y_c;
  logic            hit_c;
  logic [P_CW-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic            out_valid_q, out_valid_d, out_hs_q, out_hs_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_done_q, out_done_d;

  assign rel_x_c = s1_x_q - act_xs;
  assign rel_y_c = s1_y_q - act_ys;
  assign hit_c   = s1_act_q && s1_hit_x_q && s1_hit_y_q;

  always_comb begin
    out_x_d     = '0;
    out_y_d     = '0;
    out_valid_d = 1'b0;
    out_hs_d    = 1'b0;
    out_data_d  = '0;
    out_done_d  = s1_last_q;
    if (hit_c) begin
      out_hs_d = 1'b1;
`ifdef CROP_DECIM2_EN
      // Keep only even relative rows and columns.
      out_x_d = rel_x_c >> 1;
      out_y_d = rel_y_c >> 1;
      if (!rel_x_c[0] && !rel_y_c[0]) begin
        out_valid_d = s1_valid_q;
        out_data_d  = s1_data_q;
      end
`else
      out_x_d     = rel_x_c;
      out_y_d     = rel_y_c;
      out_valid_d = s1_valid_q;
      out_data_d  = s1_data_q;
`endif
    end
  end

  always_ff @(posedge in_pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      out_hs_q    <= 1'b0;
      out_data_q  <= '0;
      out_done_q  <= 1'b0;
    end else begin
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      out_hs_q    <= out_hs_d;
      out_data_q  <= out_data_d;
      out_done_q  <= out_done_d;
    end
  end

  assign out_x          = out_x_q;
  assign out_y          = out_y_q;
  assign out_valid      = out_valid_q;
  assign out_hs         = out_hs_q;
  assign out_data       = out_data_q;
  assign out_frame_done = out_done_q;
  assign err_trunc      = err_q;

endmodule

// File: tb/tb_crop_roi_dyn.sv
// Directed bench for crop_roi_dyn: frames driven in raster order, output
// beats captured on the falling edge and checked against hand-derived values.
module tb_crop_roi_dyn;

  localparam int unsigned DEPTH = 10;
  localparam int unsigned CH    = 3;
  localparam int unsigned CW    = 11;
  localparam int unsigned DW    = CH * DEPTH;

  logic          in_pclk = 1'b0;
  logic          in_arstn;
  logic [CW-1:0] cfg_x_start, cfg_x_win, cfg_y_start, cfg_y_win;
  logic          cfg_update;
  logic [CW-1:0] in_x, in_y;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] out_x, out_y;
  logic          out_valid, out_hs, out_frame_done, err_trunc;
  logic [DW-1:0] out_data;

  always #5 in_pclk = ~in_pclk;

  crop_roi_dyn #(.P_DEPTH(DEPTH), .P_CH(CH), .P_CW(CW)) dut (
    .in_pclk        (in_pclk),
    .in_arstn       (in_arstn),
    .cfg_x_start    (cfg_x_start),
    .cfg_x_win      (cfg_x_win),
    .cfg_y_start    (cfg_y_start),
    .cfg_y_win      (cfg_y_win),
    .cfg_update     (cfg_update),
    .in_x           (in_x),
    .in_y           (in_y),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_x          (out_x),
    .out_y          (out_y),
    .out_valid      (out_valid),
    .out_hs         (out_hs),
    .out_data       (out_data),
    .out_frame_done (out_frame_done),
    .err_trunc      (err_trunc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge in_pclk) cyc <= cyc + 1;

  typedef struct {
    int            x;
    int            y;
    logic [DW-1:0] d;
    logic          done;
    int            c;
  } beat_t;

  beat_t beats[$];
  int    hs_cnt, done_cnt, probe_cyc, probe_x, probe_y;
  bit    cap_en = 1'b0;

  // Capture of every output beat and pulse while a frame is running.
  always @(negedge in_pclk) begin
    if (cap_en) begin
      if (out_valid) begin
        beat_t b;
        b.x = int'(out_x); b.y = int'(out_y); b.d = out_data;
        b.done = out_frame_done; b.c = cyc;
        beats.push_back(b);
      end
      if (out_hs) hs_cnt++;
      if (out_frame_done) done_cnt++;
    end
  end

  function automatic logic [DW-1:0] pix(input int x, input int y);
    return {DEPTH'(y), DEPTH'(x), DEPTH'(3 * x + y)};
  endfunction

  task automatic drive(input int x, input int y, input bit v);
    in_x = CW'(x); in_y = CW'(y); in_valid = v;
    in_data = v ? pix(x, y) : '0;
    if (x == probe_x && y == probe_y) probe_cyc = cyc;
    @(posedge in_pclk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_x = '0; in_y = '0; in_data = '0;
    repeat (n) begin @(posedge in_pclk); #1; end
  endtask

  task automatic pulse_cfg(input int xs, input int xw, input int ys, input int yw);
    cfg_x_start = CW'(xs); cfg_x_win = CW'(xw);
    cfg_y_start = CW'(ys); cfg_y_win = CW'(yw);
    cfg_update = 1'b1;
    @(posedge in_pclk); #1;
    cfg_update = 1'b0;
  endtask

  // Full w x h frame; optional cfg_update at (0,upd_y); gaps keeps x==0 and odd x valid.
  task automatic run_frame(input int w, input int h, input int upd_y, input bit gaps);
    beats.delete(); hs_cnt = 0; done_cnt = 0; cap_en = 1'b1;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        cfg_update = (y == upd_y) && (x == 0);
        drive(x, y, gaps ? ((x == 0) || (x % 2 == 1)) : 1'b1);
      end
    cfg_update = 1'b0;
    idle(4);
    cap_en = 1'b0;
  endtask

  task automatic test_reset();
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++;
    if (out_hs !== 1'b0) begin n_bad++; $display("FAIL reset_hs got %b want 0", out_hs); end
    n_cmp++;
    if (out_x !== '0 || out_y !== '0) begin n_bad++; $display("FAIL reset_xy got %0d,%0d want 0,0", out_x, out_y); end
    n_cmp++;
    if (out_data !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", out_data); end
    n_cmp++;
    if (out_frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", out_frame_done); end
    n_cmp++;
    if (err_trunc !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_trunc); end
    n_cmp++;
  endtask

  task automatic test_basic();
    pulse_cfg(4, 8, 2, 3);
    probe_x = 4; probe_y = 2;
    run_frame(16, 8, -1, 1'b0);
    probe_x = -1;
    if (beats.size() != 24) begin n_bad++; $display("FAIL basic_count got %0d want 24", beats.size()); end
    n_cmp++;
    if (beats.size() == 24) begin
      if (beats[0].x != 0 || beats[0].y != 0 || beats[0].d !== pix(4, 2)) begin
        n_bad++; $display("FAIL basic_first got (%0d,%0d,%h) want (0,0,%h)", beats[0].x, beats[0].y, beats[0].d, pix(4, 2));
      end
      n_cmp++;
      if (beats[23].x != 7 || beats[23].y != 2 || beats[23].d !== pix(11, 4) || beats[23].done !== 1'b1) begin
        n_bad++; $display("FAIL basic_last got (%0d,%0d,%h,done=%b) want (7,2,%h,done=1)", beats[23].x, beats[23].y, beats[23].d, beats[23].done, pix(11, 4));
      end
      n_cmp++;
      if (beats[0].c - probe_cyc != 2) begin n_bad++; $display("FAIL basic_latency got %0d want 2", beats[0].c - probe_cyc); end
      n_cmp++;
      for (int i = 0; i < 24; i++) begin
        if (beats[i].x != i % 8 || beats[i].y != i / 8 || beats[i].d !== pix(4 + i % 8, 2 + i / 8)) begin
          n_bad++; $display("FAIL basic_beat%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", i, beats[i].x, beats[i].y, beats[i].d, i % 8, i / 8, pix(4 + i % 8, 2 + i / 8));
        end
        n_cmp++;
      end
    end
    if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
    n_cmp++;
    if (err_trunc !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b want 0", err_trunc); end
    n_cmp++;
  endtask

  task automatic test_clip();
    pulse_cfg(12, 8, 2, 3);
    run_frame(16, 8, -1, 1'b0);
    if (beats.size() != 12) begin n_bad++; $display("FAIL clip_count got %0d want 12", beats.size()); end
    n_cmp++;
    if (beats.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        if (beats[i].x != i % 4 || beats[i].y != i / 4 || beats[i].d !== pix(12 + i % 4, 2 + i / 4)) begin
          n_bad++; $display("FAIL clip_beat%0d got (%0d,%0d,%h) want (%0d,%0d)", i, beats[i].x, beats[i].y, beats[i].d, i % 4, i / 4);
        end
        n_cmp++;
      end
    end
    if (done_cnt != 0) begin n_bad++; $display("FAIL clip_done_cnt got %0d want 0", done_cnt); end
    n_cmp++;
    if (err_trunc !== 1'b0) begin n_bad++; $display("FAIL clip_err got %b want 0", err_trunc); end
    n_cmp++;
  endtask

  // Previous frame never completed: the next SOF flags truncation.
  task automatic test_trunc();
    pulse_cfg(4, 8, 2, 3);
    if (err_trunc !== 1'b0) begin n_bad++; $display("FAIL trunc_pre got %b want 0", err_trunc); end
    n_cmp++;
    run_frame(16, 8, -1, 1'b0);
    if (err_trunc !== 1'b1) begin n_bad++; $display("FAIL trunc_err got %b want 1", err_trunc); end
    n_cmp++;
    if (beats.size() != 24 || done_cnt != 1) begin n_bad++; $display("FAIL trunc_frame got %0d beats %0d done want 24 1", beats.size(), done_cnt); end
    n_cmp++;
  endtask

  task automatic test_midframe_update();
    cfg_x_win = CW'(4);
    run_frame(16, 8, 3, 1'b0);
    if (err_trunc !== 1'b0) begin n_bad++; $display("FAIL mid_err_clear got %b want 0", err_trunc); end
    n_cmp++;
    if (beats.size() != 24 || done_cnt != 1) begin n_bad++; $display("FAIL mid_cur_frame got %0d beats %0d done want 24 1", beats.size(), done_cnt); end
    n_cmp++;
    run_frame(16, 8, -1, 1'b0);
    if (beats.size() != 12) begin n_bad++; $display("FAIL mid_next_count got %0d want 12", beats.size()); end
    n_cmp++;
    if (beats.size() == 12) begin
      if (beats[11].x != 3 || beats[11].y != 2 || beats[11].d !== pix(7, 4) || beats[11].done !== 1'b1) begin
        n_bad++; $display("FAIL mid_next_last got (%0d,%0d,%h,done=%b) want (3,2,%h,done=1)", beats[11].x, beats[11].y, beats[11].d, beats[11].done, pix(7, 4));
      end
      n_cmp++;
    end
    if (err_trunc !== 1'b0) begin n_bad++; $display("FAIL mid_next_err got %b want 0", err_trunc); end
    n_cmp++;
  endtask

  task automatic test_gaps();
    pulse_cfg(4, 8, 2, 3);
    run_frame(16, 8, -1, 1'b1);
    if (beats.size() != 12) begin n_bad++; $display("FAIL gaps_count got %0d want 12", beats.size()); end
    n_cmp++;
    if (hs_cnt != 24) begin n_bad++; $display("FAIL gaps_hs got %0d want 24", hs_cnt); end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL gaps_done got %0d want 1", done_cnt); end
    n_cmp++;
    if (beats.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        if (beats[i].x != 1 + 2 * (i % 4) || beats[i].y != i / 4 || beats[i].d !== pix(5 + 2 * (i % 4), 2 + i / 4)) begin
          n_bad++; $display("FAIL gaps_beat%0d got (%0d,%0d,%h) want (%0d,%0d)", i, beats[i].x, beats[i].y, beats[i].d, 1 + 2 * (i % 4), i / 4);
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_zero_window();
    pulse_cfg(4, 0, 2, 3);
    run_frame(16, 8, -1, 1'b0);
    if (beats.size() != 0 || hs_cnt != 0 || done_cnt != 0) begin
      n_bad++; $display("FAIL zero_outputs got %0d beats %0d hs %0d done want 0 0 0", beats.size(), hs_cnt, done_cnt);
    end
    n_cmp++;
    pulse_cfg(4, 8, 2, 3);
    run_frame(16, 8, -1, 1'b0);
    if (err_trunc !== 1'b0) begin n_bad++; $display("FAIL zero_no_err got %b want 0", err_trunc); end
    n_cmp++;
    if (beats.size() != 24 || done_cnt != 1) begin n_bad++; $display("FAIL zero_next_frame got %0d beats %0d done want 24 1", beats.size(), done_cnt); end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    pulse_cfg(4, 8, 2, 3);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 16; x++) drive(x, y, 1'b1);
    for (int x = 0; x < 6; x++) drive(x, 3, 1'b1);
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid got %b want 1", out_valid); end
    n_cmp++;
    #1 in_arstn = 1'b0;
    #1;
    if (out_valid !== 1'b0 || out_hs !== 1'b0 || out_x !== '0 || out_y !== '0 ||
        out_data !== '0 || out_frame_done !== 1'b0 || err_trunc !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_outputs got v=%b hs=%b x=%0d y=%0d d=%h done=%b err=%b want all 0",
                        out_valid, out_hs, out_x, out_y, out_data, out_frame_done, err_trunc);
    end
    n_cmp++;
    idle(2);
    in_arstn = 1'b1;
    idle(4);
    pulse_cfg(4, 8, 2, 3);
    run_frame(16, 8, -1, 1'b0);
    if (beats.size() != 24 || done_cnt != 1) begin n_bad++; $display("FAIL rstmid_frame got %0d beats %0d done want 24 1", beats.size(), done_cnt); end
    n_cmp++;
    if (beats.size() == 24) begin
      if (beats[23].x != 7 || beats[23].y != 2 || beats[23].d !== pix(11, 4)) begin
        n_bad++; $display("FAIL rstmid_last got (%0d,%0d,%h) want (7,2,%h)", beats[23].x, beats[23].y, beats[23].d, pix(11, 4));
      end
      n_cmp++;
    end
    if (err_trunc !== 1'b0) begin n_bad++; $display("FAIL rstmid_err got %b want 0", err_trunc); end
    n_cmp++;
  endtask

  task automatic test_decim();
    pulse_cfg(4, 8, 2, 4);
    run_frame(16, 8, -1, 1'b0);
    if (beats.size() != 8) begin n_bad++; $display("FAIL decim_count got %0d want 8", beats.size()); end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL decim_done got %0d want 1", done_cnt); end
    n_cmp++;
    if (beats.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        if (beats[i].x != i % 4 || beats[i].y != i / 4 || beats[i].d !== pix(4 + 2 * (i % 4), 2 + 2 * (i / 4))) begin
          n_bad++; $display("FAIL decim_beat%0d got (%0d,%0d,%h) want (%0d,%0d)", i, beats[i].x, beats[i].y, beats[i].d, i % 4, i / 4);
        end
        n_cmp++;
      end
      if (beats[7].done !== 1'b0) begin n_bad++; $display("FAIL decim_done_on_beat got %b want 0", beats[7].done); end
      n_cmp++;
    end
    if (hs_cnt != 32) begin n_bad++; $display("FAIL decim_hs got %0d want 32", hs_cnt); end
    n_cmp++;
  endtask

  initial begin
    in_arstn = 1'b0; cfg_update = 1'b0;
    cfg_x_start = '0; cfg_x_win = '0; cfg_y_start = '0; cfg_y_win = '0;
    in_x = '0; in_y = '0; in_valid = 1'b0; in_data = '0;
    probe_x = -1; probe_y = -1; probe_cyc = 0;
    repeat (3) @(posedge in_pclk);
    #1 in_arstn = 1'b1;
    idle(3);
    test_reset();
`ifdef CROP_DECIM2_EN
    test_decim();
`else
    test_basic();
    test_clip();
    test_trunc();
    test_midframe_update();
    test_gaps();
    test_zero_window();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crop_roi_dyn.md
Name: crop_roi_dyn

Overview:
- Runtime-configurable region-of-interest crop for the camera pixel stream.
- Successor to the fixed-window crop:
  - window origin and size come from registers, not parameters;
  - channel count and coordinate width are parametrised;
  - adds frame-boundary config shadowing, a frame-done pulse and a truncation error flag.
- Sits between the debayer/pixel-window stage and the downscaler feeding the inference buffer.

Parameters:
- P_DEPTH, 10, bits per channel sample
- P_CH, 3, channels per pixel beat (packed, ch0 in LSBs)
- P_CW, 11, width of x/y coordinates and window config fields

Ports:
- in_pclk  in  1  pixel clock
- in_arstn  in  1  asynchronous active-low reset
- cfg_x_start  in  P_CW  window left column
- cfg_x_win  in  P_CW  window width in pixels
- cfg_y_start  in  P_CW  window top row
- cfg_y_win  in  P_CW  window height in rows
- cfg_update  in  1  one-cycle pulse; captures cfg_* into the pending set
- in_x  in  P_CW  input column
- in_y  in  P_CW  input row
- in_valid  in  1  input pixel valid
- in_data  in  P_CH*P_DEPTH  input pixel
- out_x  out  P_CW  column relative to window
- out_y  out  P_CW  row relative to window
- out_valid  out  1  output pixel valid
- out_hs  out  1  high while the input column is inside the window span, on active rows
- out_data  out  P_CH*P_DEPTH  cropped pixel
- out_frame_done  out  1  one-cycle pulse with the last window pixel
- err_trunc  out  1  sticky: a frame started before the previous window completed

Behaviour:
- Reset: async assert, sync release. All outputs 0, FSM in WAIT_SOF, pending and active config 0, pending-valid flag 0.
- Config path:
  - cfg_update loads the pending set and sets pending-valid.
  - At SOF (in_valid && in_x==0 && in_y==0), if pending-valid: active <= pending, pending-valid cleared.
  - Active config never changes mid-frame.
- Window test, on active config, widened to P_CW+1 bits so no wrap:
  - hit_x = in_x >= xs && in_x < xs+xw
  - hit_y = in_y >= ys && in_y < ys+yw
  - A window that extends past the sensor edge is simply clipped.
- FSM:
  - WAIT_SOF -> ACTIVE on SOF.
  - ACTIVE -> DONE when the last pixel is accepted: in_valid && in_x==xs+xw-1 && in_y==ys+yw-1.
  - DONE -> ACTIVE on next SOF.
  - SOF while in ACTIVE: set err_trunc and restart ACTIVE. out_frame_done is not pulsed.
- Latency: fixed 2 cycles, in_* to out_*.
  - Stage 1 registers inputs plus hit flags.
  - Stage 2 computes out_x = in_x - xs and out_y = in_y - ys (mod 2^P_CW; valid because hit implies no underflow).
- Output gating, only in ACTIVE:
  - out_valid = in_valid && hit_x && hit_y.
  - out_hs = hit_x && hit_y, independent of in_valid.
  - When not hit: out_x, out_y and out_data are driven 0.
- out_frame_done is asserted on the same output cycle as the last window pixel.
- Zero-size window (xw==0 or yw==0): no out_valid. FSM stays ACTIVE until the next SOF; err_trunc is not set in this case.
- cfg_update on the same cycle as SOF: the new values go to pending and apply at the following SOF; the current SOF uses the old pending set.
- err_trunc clears on cfg_update.
- Reset mid-frame: outputs drop to 0 asynchronously; the next SOF restarts cleanly.

Optional Feature:
- CROP_DECIM2_EN defined: 2:1 decimation in both axes inside the window.
  - out_valid only when relative x and relative y are both even.
  - out_x = rel_x>>1, out_y = rel_y>>1.
  - out_hs unchanged.
  - out_frame_done fires on the last window pixel, even if that pixel is dropped; data is 0 in that case.
- Not defined: full-resolution crop as above.
- Latency is 2 cycles either way.

Decomposition:
- Package crop_pkg:
  - FSM state encoding (WAIT_SOF, ACTIVE, DONE);
  - default widths;
  - SOF and last-pixel comparison helper functions.
- Sub-module crop_cfg_shadow holds the pending/active register pair, pending-valid flag and SOF swap.

Test Plan:
- Config xs=4, xw=8, ys=2, yw=3, then a 16x8 frame -> 24 out_valid beats; first beat out_x=0,out_y=0 carries in(4,2); last beat out_x=7,out_y=2 carries in(11,4) and out_frame_done=1; latency is 2 cycles.
- Window xs=12, xw=8 on a 16-wide frame -> 4 columns per row (out_x 0..3); no last-pixel match, so out_frame_done=0; a second SOF sets err_trunc=1.
- cfg_update mid-frame changing xw from 8 to 4 -> current frame still 8 wide; next frame 4 wide.
- in_valid toggled 50% during the window -> out_valid mirrors the gaps; out_hs stays high across the window columns.
- Assert in_arstn=0 mid-window -> all outputs 0 immediately; after release, the next SOF yields a full correct frame.
- With CROP_DECIM2_EN and an 8x4 window -> 8 beats, out_x 0..3, out_y 0..1; out_frame_done pulses once.
